// File: rtl/compar_debounce.sv
// Debounce filter for compar_nbit flags: commits a relation state after K
// consecutive identical valid samples, counts commits and flags illegal inputs.
module compar_debounce #(
    parameter int K  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          smaller,
    input  logic          equal,
    input  logic          greater,
    output logic [1:0]    state,
    output logic          changed,
    output logic [CW-1:0] chg_cnt,
    output logic          err
);
    localparam int RW = (K < 2) ? 1 : $clog2(K + 1);

    localparam logic [1:0] S_UNK = 2'b00;
    localparam logic [1:0] S_LT  = 2'b01;
    localparam logic [1:0] S_EQ  = 2'b10;
    localparam logic [1:0] S_GT  = 2'b11;

    logic [RW-1:0] run, nrun;
    logic [1:0]    cand, cls;
    logic          legal, ena;

    always_comb begin
        legal = 1'b1;
        cls   = S_UNK;
        case ({smaller, equal, greater})
            3'b100:  cls = S_LT;
            3'b010:  cls = S_EQ;
            3'b001:  cls = S_GT;
            default: legal = 1'b0;
        endcase
        // A run only continues if it was actually started toward this class
        nrun = (cls == cand && run != '0) ? run + 1'b1 : RW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena     <= 1'b0;
            state   <= S_UNK;
            changed <= 1'b0;
            chg_cnt <= '0;
            err     <= 1'b0;
            run     <= '0;
            cand    <= S_UNK;
        end else begin
            // ena delays sample acceptance to the second edge after release
            ena     <= 1'b1;
            changed <= 1'b0;
            if (ena && in_valid) begin
                if (!legal) begin
                    run <= '0;
                    err <= 1'b1;
                end else if (cls == state) begin
                    run  <= '0;
                    cand <= state;
                end else begin
                    cand <= cls;
                    if (nrun == RW'(K)) begin
                        state   <= cls;
                        run     <= '0;
                        changed <= 1'b1;
                        if (state != S_UNK && !(&chg_cnt))
                            chg_cnt <= chg_cnt + 1'b1;
                    end else begin
                        run <= nrun;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_compar_debounce.sv
// Directed bench for compar_debounce: one K=4/CW=8 instance and one
// K=1/CW=2 instance share the same stimulus.
module tb_compar_debounce;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, smaller = 1'b0, equal = 1'b0, greater = 1'b0;

    logic [1:0] a_state, b_state;
    logic       a_changed, b_changed, a_err, b_err;
    logic [7:0] a_cnt;
    logic [1:0] b_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] F_LT = 3'b100;
    localparam logic [2:0] F_EQ = 3'b010;
    localparam logic [2:0] F_GT = 3'b001;

    compar_debounce #(.K(4), .CW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .smaller(smaller), .equal(equal), .greater(greater),
        .state(a_state), .changed(a_changed), .chg_cnt(a_cnt), .err(a_err)
    );

    compar_debounce #(.K(1), .CW(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .smaller(smaller), .equal(equal), .greater(greater),
        .state(b_state), .changed(b_changed), .chg_cnt(b_cnt), .err(b_err)
    );

    always #5 clk = ~clk;

    // Present one sample across a rising edge, return 1 time unit after it.
    task automatic drive(input logic [2:0] f, input logic v);
        @(negedge clk);
        {smaller, equal, greater} = f;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    // Hold reset, release it with flags f presented valid, return after edge 1.
    task automatic apply_reset(input logic [2:0] f);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        {smaller, equal, greater} = f;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Four GT samples after release; the sample seen on edge 1 must be ignored.
    task automatic first_commit(input string tag);
        apply_reset(F_GT);
        checks++;
        if (a_state !== 2'b00) begin
            errors++; $display("FAIL %s_edge1 state=%b exp=00", tag, a_state);
        end
        for (int i = 0; i < 3; i++) begin
            drive(F_GT, 1'b1);
            checks++;
            if (a_state !== 2'b00 || a_changed !== 1'b0) begin
                errors++;
                $display("FAIL %s_pre%0d state=%b changed=%b exp=00/0", tag, i, a_state, a_changed);
            end
        end
        drive(F_GT, 1'b1);
        checks++;
        if (a_state !== 2'b11 || a_changed !== 1'b1 || a_cnt !== 8'd0) begin
            errors++;
            $display("FAIL %s_commit state=%b changed=%b cnt=%0d exp=11/1/0", tag, a_state, a_changed, a_cnt);
        end
        drive(F_GT, 1'b0);
        checks++;
        if (a_state !== 2'b11 || a_changed !== 1'b0) begin
            errors++;
            $display("FAIL %s_after state=%b changed=%b exp=11/0", tag, a_state, a_changed);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (a_state !== 2'b00 || a_changed !== 1'b0 || a_cnt !== 8'd0 || a_err !== 1'b0 ||
            b_state !== 2'b00 || b_changed !== 1'b0 || b_cnt !== 2'd0 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values a=%b/%b/%0d/%b b=%b/%b/%0d/%b exp all zero",
                     a_state, a_changed, a_cnt, a_err, b_state, b_changed, b_cnt, b_err);
        end
        first_commit("reset");
    endtask

    task automatic test_glitch();
        logic [2:0] seq [8];
        logic [1:0] exp [8];
        seq = '{F_LT, F_LT, F_LT, F_GT, F_LT, F_LT, F_LT, F_LT};
        exp = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01};
        for (int i = 0; i < 8; i++) begin
            drive(seq[i], 1'b1);
            checks++;
            if (a_state !== exp[i] || a_changed !== (i == 7)) begin
                errors++;
                $display("FAIL glitch_%0d state=%b changed=%b exp=%b/%b", i, a_state, a_changed, exp[i], (i == 7));
            end
        end
        checks++;
        if (a_cnt !== 8'd1) begin
            errors++; $display("FAIL glitch_cnt cnt=%0d exp=1", a_cnt);
        end
    endtask

    task automatic test_gaps();
        int pulses;
        repeat (4) drive(F_EQ, 1'b1);
        checks++;
        if (a_state !== 2'b10 || a_cnt !== 8'd2) begin
            errors++; $display("FAIL gaps_to_eq state=%b cnt=%0d exp=10/2", a_state, a_cnt);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                drive(F_GT, 1'b0);
                if (a_changed === 1'b1) pulses++;
            end
            drive(F_GT, 1'b1);
            if (a_changed === 1'b1) pulses++;
            if (i == 2) begin
                checks++;
                if (a_state !== 2'b10) begin
                    errors++; $display("FAIL gaps_third state=%b exp=10", a_state);
                end
            end
        end
        drive(F_GT, 1'b0);
        if (a_changed === 1'b1) pulses++;
        checks++;
        if (a_state !== 2'b11 || a_cnt !== 8'd3 || pulses != 1) begin
            errors++;
            $display("FAIL gaps_commit state=%b cnt=%0d pulses=%0d exp=11/3/1", a_state, a_cnt, pulses);
        end
    endtask

    task automatic test_illegal();
        repeat (3) drive(F_LT, 1'b1);
        checks++;
        if (a_err !== 1'b0) begin
            errors++; $display("FAIL illegal_pre err=%b exp=0", a_err);
        end
        drive(3'b000, 1'b1);
        checks++;
        if (a_err !== 1'b1 || a_state !== 2'b11) begin
            errors++; $display("FAIL illegal_flag err=%b state=%b exp=1/11", a_err, a_state);
        end
        repeat (3) drive(F_LT, 1'b1);
        checks++;
        if (a_state !== 2'b11) begin
            errors++; $display("FAIL illegal_restart state=%b exp=11", a_state);
        end
        drive(F_LT, 1'b1);
        checks++;
        if (a_state !== 2'b01 || a_cnt !== 8'd4 || a_changed !== 1'b1 || a_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_commit state=%b cnt=%0d changed=%b err=%b exp=01/4/1/1",
                     a_state, a_cnt, a_changed, a_err);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [6];
        exp_cnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        apply_reset(3'b000);
        for (int i = 0; i < 6; i++) begin
            drive((i % 2 == 0) ? F_LT : F_GT, 1'b1);
            checks++;
            if (b_state !== ((i % 2 == 0) ? 2'b01 : 2'b11) || b_changed !== 1'b1 || b_cnt !== exp_cnt[i]) begin
                errors++;
                $display("FAIL sat_%0d state=%b changed=%b cnt=%0d exp_cnt=%0d", i, b_state, b_changed, b_cnt, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_async();
        apply_reset(3'b000);
        repeat (4) drive(F_GT, 1'b1);
        repeat (4) drive(F_EQ, 1'b1);
        repeat (4) drive(F_GT, 1'b1);
        drive(3'b110, 1'b1);
        checks++;
        if (a_state !== 2'b11 || a_cnt !== 8'd2 || a_err !== 1'b1) begin
            errors++; $display("FAIL async_setup state=%b cnt=%0d err=%b exp=11/2/1", a_state, a_cnt, a_err);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_state !== 2'b00 || a_changed !== 1'b0 || a_cnt !== 8'd0 || a_err !== 1'b0 ||
            b_state !== 2'b00 || b_cnt !== 2'd0 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL async_clear a=%b/%b/%0d/%b b=%b/%0d/%b exp all zero",
                     a_state, a_changed, a_cnt, a_err, b_state, b_cnt, b_err);
        end
        first_commit("async");
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_gaps();
        test_illegal();
        test_saturation();
        test_async();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/compar_debounce.md
# compar_debounce

Sequential filter directly downstream of `compar_nbit`: it takes the comparator's `smaller`/`equal`/`greater` flags on each valid sample and commits a stable relation state only after K consecutive identical samples. It emits a one-cycle change pulse and a saturating count of committed state changes. It also flags illegal flag combinations, giving the rest of the design a glitch-free view of the comparison result.

## Interface
- `K`, default 4: consecutive identical valid samples required to commit a new state; legal range 1..255.
- `CW`, default 8: width of `chg_cnt`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  sample qualifier; flags are ignored when low.
- `smaller`  in  1  comparator flag a<b.
- `equal`  in  1  comparator flag a==b.
- `greater`  in  1  comparator flag a>b.
- `state`  out  2  committed relation: 00 UNK, 01 LT, 10 EQ, 11 GT.
- `changed`  out  1  one-cycle pulse, high in the cycle `state` takes a new value.
- `chg_cnt`  out  CW  saturating count of committed changes.
- `err`  out  1  sticky; set by any valid sample whose flags are not one-hot.

## Operation
- Classify each sample with `in_valid`=1:
  - 100 → LT, 010 → EQ, 001 → GT (order smaller, equal, greater).
  - Any other combination (000, or two or more set) is illegal.
- Internal registers:
  - `cand` (2 bits), the candidate class.
  - `run`, the run counter, width clog2(K+1) bits, saturating at K.
- Per valid, legal sample of class C:
  - C == `state`: `run` ← 0, `cand` ← `state`. No output change.
  - C != `state` and C == `cand` with `run` ≥ 1: `run` ← `run`+1.
  - C != `state` and otherwise: `cand` ← C, `run` ← 1.
  - If the updated run value equals K: `state` ← C, `run` ← 0, `changed` ← 1.
  - `chg_cnt` ← `chg_cnt`+1 on that commit, unless it is already all-ones.
  - The commit out of UNK (the first commit) does not increment `chg_cnt`.
- Valid, illegal sample: discarded, `run` ← 0, `err` ← 1. `state` and `cand` hold.
- `in_valid`=0: every register holds. Gaps do not break a run.
- With K=1, every legal sample whose class differs from `state` commits immediately.
- UNK is never re-entered except by reset.

## Timing
- Reset (async assert, any time, including mid-run) drives:
  - `state`=00, `changed`=0, `chg_cnt`=0, `err`=0, `run`=0, `cand`=00.
- Reset release is synchronised internally. The first sample is accepted on the second rising edge after `rst_n` rises.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Commit latency: `state` updates on the same rising edge that samples the K-th consecutive matching valid sample.
- `changed` is high for exactly the clock cycle following that edge, then returns low. This holds even if another commit occurs on the next edge (K=1): in that case `changed` stays high, one cycle per commit.
- Throughput: one sample per cycle; no back-pressure.

## Test plan
- **Reset/first commit:** K=4. Drive 4 consecutive valid GT samples after reset.
  - `state` becomes 11 on the 4th edge, with `changed` pulsed once.
  - `chg_cnt` stays 0 because the commit is out of UNK.
- **Glitch rejection:** from GT, drive LT,LT,LT,GT,LT,LT,LT,LT.
  - `state` stays 11 through the GT sample.
  - It becomes 01 only on the final LT; `chg_cnt`=1.
- **Valid gaps:** from EQ, drive GT with `in_valid` low for 3 cycles between each of 4 GT samples.
  - Commit to 11 on the 4th valid sample.
  - `changed` pulses exactly once.
- **Illegal flags:** in mid-run (run=3 toward LT), drive flags 000 with `in_valid`=1.
  - `err`=1 and stays high.
  - The run restarts, so 4 further LT samples are needed to commit.
- **Saturation:** CW=2, K=1. Alternate LT/GT for 6 samples.
  - `chg_cnt` stops at 3.
  - `changed` is high in every cycle of alternation.
- **Async reset mid-operation:** assert `rst_n`=0 between edges while `state`=11, `chg_cnt`=2, `err`=1.
  - All outputs clear immediately, without waiting for a clock edge.
  - After release, behaviour matches the reset/first-commit scenario.
